// File: rtl/register_file_32x32_pkg.sv
// Shared widths and constants for the 32x32 CPU register file.
package register_file_32x32_pkg;
    localparam int DATA_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_COUNT      = 32;
    localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;
endpackage

// File: rtl/register_file_32x32_if.sv
// Register-file bus: one write port, two read ports, read/write strobes.
interface register_file_32x32_if;
    import register_file_32x32_pkg::*;
    logic                      READ;
    logic                      WRITE;
    logic [REG_ADDR_WIDTH-1:0] ADDR_R1;
    logic [REG_ADDR_WIDTH-1:0] ADDR_R2;
    logic [REG_ADDR_WIDTH-1:0] ADDR_W;
    logic [DATA_WIDTH-1:0]     DATA_W;
    logic [DATA_WIDTH-1:0]     DATA_R1;
    logic [DATA_WIDTH-1:0]     DATA_R2;

    modport master (
        output READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
        input  DATA_R1, DATA_R2
    );
    modport slave (
        input  READ, WRITE, ADDR_R1, ADDR_R2, ADDR_W, DATA_W,
        output DATA_R1, DATA_R2
    );
endinterface

// File: rtl/decoder_5x32.sv
// Write-address one-hot decode, gated by the write strobe.
module decoder_5x32
    import register_file_32x32_pkg::*;
(
    input  logic                      i_en,
    input  logic [REG_ADDR_WIDTH-1:0] i_addr,
    output logic [REG_COUNT-1:0]      o_onehot
);
    // The enable is tested first so an unknown address with i_en=0 yields all zeros.
    always_comb begin
        o_onehot = '0;
        if (i_en) o_onehot[i_addr] = 1'b1;
    end
endmodule

// File: rtl/mux32_32x1.sv
// 32-bit wide, 32-input read multiplexer.
module mux32_32x1
    import register_file_32x32_pkg::*;
(
    input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] i_d,
    input  logic [REG_ADDR_WIDTH-1:0]            i_sel,
    output logic [DATA_WIDTH-1:0]                o_y
);
    assign o_y = i_d[i_sel];
endmodule

// File: rtl/reg32_ld.sv
// 32-bit D register with load enable and asynchronous active-high reset to 0.
module reg32_ld
    import register_file_32x32_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ld,
    input  logic [DATA_WIDTH-1:0] i_d,
    output logic [DATA_WIDTH-1:0] o_q
);
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     r_q <= '0;
        else if (i_ld) r_q <= i_d;
    end

    assign o_q = r_q;
endmodule

// File: rtl/register_file_32x32.sv
// CPU register file: r0 hardwired to zero, registers 1-31, two registered
// read ports with read-before-write ordering on a shared edge.
module register_file_32x32
    import register_file_32x32_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    register_file_32x32_if.slave  bus
);
    logic [REG_COUNT-1:0]                 w_wr_en;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] w_regs;
    logic [DATA_WIDTH-1:0]                w_mux_r1;
    logic [DATA_WIDTH-1:0]                w_mux_r2;
    logic                                 w_unused_wr0;

    decoder_5x32 u_dec (
        .i_en     (bus.WRITE),
        .i_addr   (bus.ADDR_W),
        .o_onehot (w_wr_en)
    );

    // r0 has no storage; its decode line is intentionally left dangling.
    assign w_regs[ZERO_REG] = '0;
    assign w_unused_wr0     = w_wr_en[ZERO_REG];

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
        reg32_ld u_reg (
            .i_clk (CLK),
            .i_rst (RST),
            .i_ld  (w_wr_en[i]),
            .i_d   (bus.DATA_W),
            .o_q   (w_regs[i])
        );
    end

    mux32_32x1 u_mux_r1 (.i_d(w_regs), .i_sel(bus.ADDR_R1), .o_y(w_mux_r1));
    mux32_32x1 u_mux_r2 (.i_d(w_regs), .i_sel(bus.ADDR_R2), .o_y(w_mux_r2));

    // Read registers sample pre-edge register contents, giving read-before-write.
    reg32_ld u_rd1 (
        .i_clk (CLK),
        .i_rst (RST),
        .i_ld  (bus.READ),
        .i_d   (w_mux_r1),
        .o_q   (bus.DATA_R1)
    );

    reg32_ld u_rd2 (
        .i_clk (CLK),
        .i_rst (RST),
        .i_ld  (bus.READ),
        .i_d   (w_mux_r2),
        .o_q   (bus.DATA_R2)
    );
endmodule

// File: doc/register_file_32x32.md
# register_file_32x32

Thirty-two 32-bit general-purpose registers with one write port and two registered read ports. The block sits directly upstream of the 32-bit 32:1 read multiplexers: its 32 register outputs feed two MUX32_32x1 instances, one per read port, whose outputs are captured into the read-data registers. It is the CPU register file; the ALU operand path and the data-path control unit consume it.

## Interface
Parameters
- none; widths are fixed by shared constants (DATA_WIDTH = 32, REG_ADDR_WIDTH = 5, REG_COUNT = 32).

Ports
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- READ  input  1  read strobe; captures both read ports at the rising edge.
- WRITE  input  1  write strobe; commits DATA_W to ADDR_W at the rising edge.
- ADDR_R1  input  5  read port 1 register index.
- ADDR_R2  input  5  read port 2 register index.
- ADDR_W  input  5  write register index.
- DATA_W  input  32  write data.
- DATA_R1  output  32  registered read data, port 1.
- DATA_R2  output  32  registered read data, port 2.

## Operation
- Reset: while RST = 1, all 32 registers, DATA_R1 and DATA_R2 are 0, independent of CLK. Reset asserted mid-operation discards any write or read at that edge.
- Register 0 is hardwired to 0. A write to ADDR_W = 0 is ignored, and reading index 0 returns 0.
- Write: at a rising edge with WRITE = 1 and ADDR_W ≠ 0, register[ADDR_W] ← DATA_W. The 5→32 one-hot write decode is gated by WRITE. Exactly one register loads, or none.
- Read: at a rising edge with READ = 1, DATA_R1 ← register[ADDR_R1] and DATA_R2 ← register[ADDR_R2]. The values sampled are the contents before that edge's write.
- With READ = 0, DATA_R1 and DATA_R2 hold their previous values.
- Simultaneous READ and WRITE to the same index: read-before-write. The output shows the old contents, and the new value is visible on the next READ.
- Both read ports may address the same register. Each returns the same value.
- No X propagation: an unknown ADDR_W with WRITE = 0 must not corrupt any register.

## Timing
- Write latency: 1 cycle. Data is in the register after the edge and readable at the following READ edge.
- Read latency: 1 cycle. DATA_Rx is valid after the READ edge and stable until the next READ edge or RST.
- Write-to-read of the same register: minimum 2 edges from WRITE to DATA_Rx showing the new value (write at edge N, READ at edge N+1).
- Combinational read mux path: register Q → MUX32_32x1 → DATA_Rx D. This is the critical path and must close in one cycle.
- RST deassertion is synchronous to CLK at the system level. The block needs no internal synchroniser.

## Structure
- Shared definitions package holds DATA_WIDTH, REG_ADDR_WIDTH, REG_COUNT and the zero-register index constant.
- Natural sub-module: reg32_ld, a 32-bit D register with load enable and asynchronous active-high reset to 0. It is instantiated 31 times for registers 1–31 and twice for the read-data registers.
- Second sub-module: decoder_5x32, the write-address one-hot decode, ANDed with WRITE.
- Read selection reuses the existing MUX32_32x1, two instances, with input I0 tied to 32'h0.

## Test plan
- Reset: drive RST = 1 mid-run, after writing 32'hDEADBEEF to r5, then READ r5/r5. Required: DATA_R1 = DATA_R2 = 0 immediately on RST, and both remain 0 after the post-reset READ.
- Write/read all: write 32'h1000_0000 + i to ri for i = 1..31, then READ pairs (i, 31−i). Required: each port returns 32'h1000_0000 + index, and r0 returns 0.
- Zero register: write 32'hFFFF_FFFF to r0, then READ r0/r0. Required: DATA_R1 = DATA_R2 = 0.
- Read-before-write: r7 = 32'hAAAA_AAAA; same edge WRITE r7 ← 32'h5555_5555 and READ r7. Required: DATA_R1 = 32'hAAAA_AAAA, and the next READ returns 32'h5555_5555.
- Hold: READ r3 (= 32'h0000_0033), then READ = 0 for 5 cycles while writing r3 ← 32'h0000_0044. Required: DATA_R1 stays 32'h0000_0033 until the next READ.
- Write-strobe gating: WRITE = 0 with ADDR_W = 9 and DATA_W = 32'h1234_5678. Required: r9 is unchanged on the next READ.
